uart_rx: RTL and testbench

- Serial receiver; the receive end of the team's UART link, opposite the transmitter inside uart_top.
- Deserialises one asynchronous frame on rx: 1 start bit, 5-8 data bits LSB first, optional parity, and 1 or 2 stop bits.
- Presents the parallel byte on rx_out with a done strobe and an error flag.
- Baud timing comes from an internal 16x-oversampling tick generator driven by the runtime baud input.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx_baud_gen.sv | 38 +++
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants,
// latched frame configuration and data-length helpers.
package uart_pkg;

  localparam int unsigned BAUD_W    = 17;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned TICK_W    = 4;

  localparam int unsigned OVS_TICKS = 16;
  localparam int unsigned MID_TICKS = 8;
  localparam int unsigned MAX_LEN   = 8;
  localparam int unsigned MIN_LEN   = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE
  } rx_state_t;

  // Frame format captured when a frame starts.
  typedef struct packed {
    logic [LEN_W-1:0] length;
    logic             parity_en;
    logic             parity_type;
    logic             stop2;
  } rx_cfg_t;

  // Effective data length: 5..8, anything else means 8.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] length);
    return (length >= LEN_W'(MIN_LEN) && length <= LEN_W'(MAX_LEN)) ? length : LEN_W'(MAX_LEN);
  endfunction

  // Mask with the low 'len' bits set.
  function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [DATA_W:0] m;
    m = ((DATA_W+1)'(1) << len) - (DATA_W+1)'(1);
    return m[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver host interface.
//   master : host side, drives enable, line and frame format, receives data.
//   slave  : receiver side.
interface uart_rx_if;
  import uart_pkg::*;

  logic              rx_start;
  logic              rx;
  logic [BAUD_W-1:0] baud;
  logic [LEN_W-1:0]  length;
  logic              parity_en;
  logic              parity_type;
  logic              stop2;
  logic [DATA_W-1:0] rx_out;
  logic              rx_done;
  logic              rx_err;

  modport master (
    output rx_start, rx, baud, length, parity_en, parity_type, stop2,
    input  rx_out, rx_done, rx_err
  );

  modport slave (
    input  rx_start, rx, baud, length, parity_en, parity_type, stop2,
    output rx_out, rx_done, rx_err
  );

endinterface

// File: rtl/uart_rx_baud_gen.sv
// Fractional accumulator producing OVS ticks per bit at the runtime baud rate.
//   clk, rst : clock, async active-low reset
//   baud     : bit rate in bit/s (0 stops the ticks)
//   tick     : one-cycle oversampling tick (registered)
module uart_rx_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned OVS      = OVS_TICKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud,
  output logic              tick
);

  localparam int unsigned ACC_W = 27;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_c;

  assign sum_c = acc + ACC_W'(baud) * ACC_W'(OVS);

  // Free-running accumulator; each wrap past CLK_FREQ is one tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum_c >= ACC_W'(CLK_FREQ)) begin
      acc  <= sum_c - ACC_W'(CLK_FREQ);
      tick <= 1'b1;
    end else begin
      acc  <= sum_c;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART frame receiver: 1 start, 5-8 data LSB first, optional parity, 1-2 stop.
//   clk, rst : clock, async active-low reset
//   bus      : uart_rx_if.slave (enable, serial line, baud, frame format in;
//              rx_out / rx_done strobe / rx_err out)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned OVS      = OVS_TICKS
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  logic              rx_meta;
  logic              rx_s;
  logic              tick;
  rx_state_t         state;
  rx_cfg_t           cfg_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rx_out_q;
  logic              rx_done_q;
  logic              rx_err_q;
  logic              par_err;
  logic              frm_err;

  logic [DATA_W-1:0] mask_c;
  logic              mid_c;
  logic              bit_end_c;
  logic              last_bit_c;
  logic              exp_par_c;

  uart_rx_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .OVS      (OVS)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .baud (bus.baud),
    .tick (tick)
  );

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  assign mask_c     = len_mask(cfg_q.length);
  assign mid_c      = tick && (tick_cnt == TICK_W'(MID_TICKS - 1));
  assign bit_end_c  = tick && (tick_cnt == TICK_W'(OVS_TICKS - 1));
  assign last_bit_c = (LEN_W'(bit_idx) == cfg_q.length - LEN_W'(1));
  assign exp_par_c  = (^(data_q & mask_c)) ^ cfg_q.parity_type;

  // Frame FSM; the tick counter wraps every OVS_TICKS so it self-aligns per bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cfg_q     <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      rx_out_q  <= '0;
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
      if (tick) tick_cnt <= tick_cnt + TICK_W'(1);

      unique case (state)
        IDLE: begin
          if (bus.rx_start && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            cfg_q    <= '{length:      eff_len(bus.length),
                          parity_en:   bus.parity_en,
                          parity_type: bus.parity_type,
                          stop2:       bus.stop2};
          end
        end
        START: begin
          if (mid_c) begin
            tick_cnt <= '0;
            state    <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_end_c) begin
            data_q[bit_idx] <= rx_s;
            bit_idx         <= bit_idx + 3'd1;
            if (last_bit_c) state <= cfg_q.parity_en ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (bit_end_c) begin
            if (rx_s != exp_par_c) par_err <= 1'b1;
            state <= STOP1;
          end
        end
        STOP1: begin
          if (bit_end_c) begin
            if (!rx_s) frm_err <= 1'b1;
            state <= cfg_q.stop2 ? STOP2 : DONE;
          end
        end
        STOP2: begin
          if (bit_end_c) begin
            if (!rx_s) frm_err <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          rx_out_q  <= data_q & mask_c;
          rx_done_q <= 1'b1;
          rx_err_q  <= par_err | frm_err;
          par_err   <= 1'b0;
          frm_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_out  = rx_out_q;
  assign bus.rx_done = rx_done_q;
  assign bus.rx_err  = rx_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built bit by bit from a
// behavioural description and drawn on the line with fractional bit timing.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 50_000_000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .OVS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        err;
    int unsigned cyc;
  } obs_t;

  obs_t        done_q[$];
  logic        bit_q[$];
  int unsigned cyc       = 0;
  int unsigned frame_cyc = 0;
  int unsigned err_leak  = 0;
  int          checks    = 0;
  int          errors    = 0;
  int          drop_k    = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every strobe; rx_err must be low outside strobes.
  always @(negedge clk) begin
    if (bus.rx_done) done_q.push_back('{data: bus.rx_out, err: bus.rx_err, cyc: cyc});
    if (!bus.rx_done && bus.rx_err) err_leak++;
  end

  // ---------------- reference model ----------------
  function automatic int model_len(input int l);
    return (l >= 5 && l <= 8) ? l : 8;
  endfunction

  function automatic logic [7:0] model_data(input logic [7:0] d, input int l);
    int unsigned full;
    full = (1 << model_len(l)) - 1;
    return d & full[7:0];
  endfunction

  // Parity bit that makes the frame correct for the chosen sense.
  function automatic logic model_par(input logic [7:0] d, input int l, input logic odd);
    return logic'($countones(model_data(d, l)) % 2) ^ odd;
  endfunction

  function automatic obs_t pop_obs();
    obs_t r;
    r.data = 'x;
    r.err  = 1'bx;
    r.cyc  = 0;
    if (done_q.size() > 0) r = done_q.pop_front();
    return r;
  endfunction

  task automatic build_frame(input logic [7:0] d, input int l, input logic pen, input logic odd,
                             input logic s2, input logic bad_par, input logic bad_stop);
    bit_q.push_back(1'b0);
    for (int i = 0; i < model_len(l); i++) bit_q.push_back(d[i]);
    if (pen) bit_q.push_back(model_par(d, l, odd) ^ bad_par);
    bit_q.push_back(1'b1);
    if (s2) bit_q.push_back(!bad_stop);
  endtask

  task automatic set_cfg(input int l, input logic pen, input logic odd, input logic s2,
                         input int unsigned baud_v);
    bus.length      = 4'(l);
    bus.parity_en   = pen;
    bus.parity_type = odd;
    bus.stop2       = s2;
    bus.baud        = 17'(baud_v);
  endtask

  // Draw the first nbits of bit_q; bit k ends at round((k+1)*CLK_FREQ/baud) cycles.
  task automatic drive_q(input int unsigned baud_v, input int nbits);
    real         cpb;
    int unsigned elapsed;
    int unsigned tgt;
    cpb     = real'(CLK_FREQ) / real'(baud_v);
    elapsed = 0;
    @(negedge clk);
    frame_cyc = cyc;
    for (int k = 0; k < nbits && k < bit_q.size(); k++) begin
      if (k == drop_k) bus.rx_start = 1'b0;
      bus.rx = bit_q[k];
      tgt = $rtoi(real'(k + 1) * cpb + 0.5);
      while (elapsed < tgt) begin
        @(negedge clk);
        elapsed++;
      end
    end
    bus.rx = 1'b1;
    bit_q.delete();
    drop_k = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.rx = 1'b1;
    bus.rx_start = 1'b1;
    set_cfg(8, 1'b0, 1'b0, 1'b0, 128000);
    rst = 1'b0;
    idle(3);
    checks++; if (bus.rx_out !== 8'h00) begin errors++; $display("FAIL reset_rx_out: got %0h expected 0", bus.rx_out); end
    checks++; if (bus.rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %0b expected 0", bus.rx_done); end
    checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err: got %0b expected 0", bus.rx_err); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
    rst = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    obs_t r;
    int   lat;
    int   exp_lat;
    set_cfg(8, 1'b1, 1'b1, 1'b0, 57600);
    build_frame(8'hAF, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_q(57600, 99);
    idle(20);
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", done_q.size()); end
    r = pop_obs();
    checks++; if (r.data !== model_data(8'hAF, 8)) begin errors++; $display("FAIL basic_data: got %0h expected %0h", r.data, model_data(8'hAF, 8)); end
    checks++; if (r.err !== 1'b0) begin errors++; $display("FAIL basic_err: got %0b expected 0", r.err); end
    exp_lat = $rtoi(10.5 * real'(CLK_FREQ) / 57600.0 + 0.5);
    lat = int'(r.cyc) - int'(frame_cyc);
    checks++; if (lat < exp_lat - 80 || lat > exp_lat + 80) begin errors++; $display("FAIL basic_latency: got %0d cycles expected %0d +/- 80", lat, exp_lat); end
  endtask

  task automatic test_short();
    obs_t       r;
    logic [7:0] d[2];
    int         l[2];
    d[0] = 8'h15; l[0] = 5;
    d[1] = 8'h3C; l[1] = 12;
    for (int i = 0; i < 2; i++) begin
      set_cfg(l[i], 1'b0, 1'b0, 1'b1, 128000);
      build_frame(d[i], l[i], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive_q(128000, 99);
      idle(20);
      checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL short_count[%0d]: got %0d expected 1", i, done_q.size()); end
      r = pop_obs();
      checks++; if (r.data !== model_data(d[i], l[i])) begin errors++; $display("FAIL short_data[%0d]: got %0h expected %0h", i, r.data, model_data(d[i], l[i])); end
      checks++; if (r.err !== 1'b0) begin errors++; $display("FAIL short_err[%0d]: got %0b expected 0", i, r.err); end
    end
  endtask

  task automatic test_parity_err();
    obs_t r;
    set_cfg(8, 1'b1, 1'b0, 1'b0, 128000);
    for (int i = 0; i < 2; i++) begin
      build_frame(8'h01, 8, 1'b1, 1'b0, 1'b0, (i == 0), 1'b0);
      drive_q(128000, 99);
      idle(20);
      checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL parity_count[%0d]: got %0d expected 1", i, done_q.size()); end
      r = pop_obs();
      checks++; if (r.data !== 8'h01) begin errors++; $display("FAIL parity_data[%0d]: got %0h expected 01", i, r.data); end
      checks++; if (r.err !== logic'(i == 0)) begin errors++; $display("FAIL parity_err[%0d]: got %0b expected %0b", i, r.err, (i == 0)); end
    end
  endtask

  task automatic test_framing();
    obs_t r;
    set_cfg(8, 1'b0, 1'b0, 1'b1, 128000);
    build_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drop_k = bit_q.size() - 1;  // keep the low stop bit from looking like a new start
    drive_q(128000, 99);
    idle(20);
    bus.rx_start = 1'b1;
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL framing_count: got %0d expected 1", done_q.size()); end
    r = pop_obs();
    checks++; if (r.data !== 8'h5A) begin errors++; $display("FAIL framing_data: got %0h expected 5a", r.data); end
    checks++; if (r.err !== 1'b1) begin errors++; $display("FAIL framing_err: got %0b expected 1", r.err); end
    // One-clock low glitch while idle: false start, no strobe.
    @(negedge clk) bus.rx = 1'b0;
    @(negedge clk) bus.rx = 1'b1;
    idle(500);
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", done_q.size()); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected IDLE", dut.state); end
  endtask

  task automatic test_enable();
    obs_t r;
    set_cfg(8, 1'b0, 1'b0, 1'b0, 128000);
    bus.rx_start = 1'b0;
    build_frame(8'hE7, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_q(128000, 99);
    idle(20);
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL disabled_count: got %0d expected 0", done_q.size()); end
    bus.rx_start = 1'b1;
    idle(5);
    build_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drop_k = 4;
    drive_q(128000, 99);
    idle(20);
    bus.rx_start = 1'b1;
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL middrop_count: got %0d expected 1", done_q.size()); end
    r = pop_obs();
    checks++; if (r.data !== 8'h96) begin errors++; $display("FAIL middrop_data: got %0h expected 96", r.data); end
    // Reset in the middle of the data bits.
    build_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_q(128000, 5);
    rst = 1'b0;
    #1;
    checks++; if (bus.rx_out !== 8'h00) begin errors++; $display("FAIL midrst_rx_out: got %0h expected 0", bus.rx_out); end
    checks++; if (bus.rx_done !== 1'b0) begin errors++; $display("FAIL midrst_rx_done: got %0b expected 0", bus.rx_done); end
    checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL midrst_rx_err: got %0b expected 0", bus.rx_err); end
    idle(3);
    rst = 1'b1;
    idle(800);
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", done_q.size()); end
    build_frame(8'h3D, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_q(128000, 99);
    idle(20);
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL postrst_count: got %0d expected 1", done_q.size()); end
    r = pop_obs();
    checks++; if (r.data !== 8'h3D) begin errors++; $display("FAIL postrst_data: got %0h expected 3d", r.data); end
  endtask

  task automatic test_back_to_back();
    obs_t       r;
    logic [7:0] d[3];
    d[0] = 8'h55; d[1] = 8'hAA; d[2] = 8'hFF;
    set_cfg(8, 1'b0, 1'b0, 1'b0, 115200);
    for (int i = 0; i < 3; i++) build_frame(d[i], 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_q(115200, 99);
    idle(20);
    checks++; if (done_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", done_q.size()); end
    for (int i = 0; i < 3; i++) begin
      r = pop_obs();
      checks++; if (r.data !== d[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, r.data, d[i]); end
      checks++; if (r.err !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d]: got %0b expected 0", i, r.err); end
    end
  endtask

  task automatic test_random();
    obs_t        r;
    logic [7:0]  d;
    int          l;
    logic        pen, odd, s2, bad;
    int unsigned baud_v;
    for (int i = 0; i < 4; i++) begin
      d      = 8'($urandom);
      l      = int'($urandom_range(4, 12));
      pen    = 1'($urandom);
      odd    = 1'($urandom);
      s2     = 1'($urandom);
      bad    = pen && ($urandom_range(0, 3) == 0);
      baud_v = ($urandom_range(0, 1) != 0) ? 115200 : 128000;
      set_cfg(l, pen, odd, s2, baud_v);
      build_frame(d, l, pen, odd, s2, bad, 1'b0);
      drive_q(baud_v, 99);
      idle(20);
      checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected 1", i, done_q.size()); end
      r = pop_obs();
      checks++; if (r.data !== model_data(d, l)) begin errors++; $display("FAIL rand_data[%0d]: got %0h expected %0h (len %0d)", i, r.data, model_data(d, l), l); end
      checks++; if (r.err !== bad) begin errors++; $display("FAIL rand_err[%0d]: got %0b expected %0b", i, r.err, bad); end
    end
  endtask

  task automatic test_err_quiet();
    checks++; if (err_leak !== 0) begin errors++; $display("FAIL err_outside_done: got %0d cycles expected 0", err_leak); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_parity_err();
    test_framing();
    test_enable();
    test_back_to_back();
    test_random();
    test_err_quiet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
